// File: rtl/io_bus_arbiter_pkg.sv
// io_bus_arbiter_pkg: shared widths, IO register map and arbiter state encoding
package io_bus_arbiter_pkg;
   localparam int XLEN = 32;
   localparam int IO_MAP_WIDTH = 5;
   localparam logic [4:0] IO_CYCLE_CNT = 5'b00100;
   localparam logic [4:0] IO_INSTR_CNT = 5'b00101;
   localparam logic [4:0] IO_CNT_RST = 5'b00110;
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} arb_state_t;
endpackage

// File: rtl/io_bus_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick, rr_ptr breaks ties
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       rr_ptr,
   output logic       any,
   output logic       winner
);
   assign any = |req;
   assign winner = &req ? rr_ptr : req[1];
endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin sharing of the IO target between two requesters, one access per grant
module io_bus_arbiter
   import io_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = IO_MAP_WIDTH,
   parameter int DATA_W = XLEN
) (
   input  logic              clk,
   input  logic              cpu_rst_n,
   input  logic              r0_req,
   input  logic [3:0]        r0_we,
   input  logic [ADDR_W-1:0] r0_adr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic [3:0]        r1_we,
   input  logic [ADDR_W-1:0] r1_adr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              io_en,
   output logic [3:0]        wea,
   output logic [ADDR_W-1:0] adr,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] dout_io
);
   arb_state_t state;
   logic any, winner, rr_ptr, win_q;
   logic [DATA_W-1:0] rdata_q;
   rr_arb2 u_arb (.req({r1_req, r0_req}), .rr_ptr(rr_ptr), .any(any), .winner(winner));
   assign r0_rdata = r0_rvalid ? rdata_q : '0;
   assign r1_rdata = r1_rvalid ? rdata_q : '0;
   // Target outputs double as the latched transaction; they are zeroed outside ACCESS
   always_ff @(posedge clk or negedge cpu_rst_n)
      if (!cpu_rst_n) begin
         state <= IDLE;
         rr_ptr <= 1'b0;
         win_q <= 1'b0;
         rdata_q <= '0;
         r0_gnt <= 1'b0;
         r1_gnt <= 1'b0;
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         io_en <= 1'b0;
         wea <= '0;
         adr <= '0;
         wdata <= '0;
      end else if (state == ACCESS) begin
         state <= RESP;
         rdata_q <= wea == 4'h0 ? dout_io : '0;
         r0_gnt <= 1'b0;
         r1_gnt <= 1'b0;
         r0_rvalid <= !win_q;
         r1_rvalid <= win_q;
         io_en <= 1'b0;
         wea <= '0;
         adr <= '0;
         wdata <= '0;
      end else begin
         state <= any ? ACCESS : IDLE;
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         if (any) begin
            win_q <= winner;
            rr_ptr <= !winner;
            r0_gnt <= !winner;
            r1_gnt <= winner;
            io_en <= 1'b1;
            wea <= winner ? r1_we : r0_we;
            adr <= winner ? r1_adr : r0_adr;
            wdata <= winner ? r1_wdata : r0_wdata;
         end
      end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed checks of grant/response timing, round-robin and reset behaviour
module tb_io_bus_arbiter;
   import io_bus_arbiter_pkg::*;
   logic clk = 1'b0;
   logic cpu_rst_n = 1'b0;
   logic r0_req = 1'b0, r1_req = 1'b0;
   logic [3:0] r0_we = '0, r1_we = '0;
   logic [4:0] r0_adr = '0, r1_adr = '0;
   logic [31:0] r0_wdata = '0, r1_wdata = '0;
   logic r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, io_en;
   logic [31:0] r0_rdata, r1_rdata, wdata;
   logic [3:0] wea;
   logic [4:0] adr;
   logic [31:0] dout_io = 32'hBAD0_BAD0;
   int checks = 0, errors = 0, gnt_cnt = 0;
   io_bus_arbiter dut (
      .clk(clk), .cpu_rst_n(cpu_rst_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_adr(r0_adr), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_adr(r1_adr), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .io_en(io_en), .wea(wea), .adr(adr), .wdata(wdata), .dout_io(dout_io)
   );
   always #5 clk = ~clk;
   function automatic logic [127:0] all_out();
      return {18'd0, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, io_en, wea, adr, wdata, r0_rdata, r1_rdata};
   endfunction
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      #1 chk("reset_outputs", all_out(), '0);
      tick();
      cpu_rst_n = 1'b1;
      tick();
      // single read by r0
      r0_req = 1'b1; r0_we = 4'h0; r0_adr = IO_CYCLE_CNT;
      tick();
      chk("rd_gnt", {r0_gnt, r1_gnt, io_en, wea, adr}, {3'b101, 4'h0, IO_CYCLE_CNT});
      r0_req = 1'b0; dout_io = 32'h0000_0123;
      tick();
      chk("rd_resp", {r0_rvalid, r1_rvalid, r0_gnt, io_en, r0_rdata, r1_rdata}, {4'b1000, 32'h123, 32'h0});
      dout_io = 32'hDEAD_BEEF;
      tick();
      chk("rd_idle", all_out(), '0);
      // write by r1
      r1_req = 1'b1; r1_we = 4'hF; r1_adr = IO_CNT_RST; r1_wdata = 32'h1;
      tick();
      chk("wr_gnt", {r1_gnt, r0_gnt, io_en, wea, adr, wdata}, {3'b101, 4'hF, IO_CNT_RST, 32'h1});
      r1_req = 1'b0;
      tick();
      chk("wr_resp", {r1_rvalid, r0_rvalid, io_en, wea, adr, wdata, r1_rdata}, {3'b100, 4'h0, 5'h0, 32'h0, 32'h0});
      tick();
      // simultaneous requests after reset
      cpu_rst_n = 1'b0; #1 cpu_rst_n = 1'b1;
      r0_req = 1'b1; r0_we = 4'h0; r0_adr = IO_CYCLE_CNT;
      r1_req = 1'b1; r1_we = 4'h0; r1_adr = IO_INSTR_CNT;
      tick();
      chk("sim_g0", {r0_gnt, r1_gnt, adr}, {2'b10, IO_CYCLE_CNT});
      r0_req = 1'b0; dout_io = 32'h111;
      tick();
      chk("sim_v0", {r0_rvalid, r1_gnt, r0_rdata}, {2'b10, 32'h111});
      dout_io = 32'hDEAD_BEEF;
      tick();
      chk("sim_g1", {r1_gnt, r0_gnt, r0_rvalid, adr}, {3'b100, IO_INSTR_CNT});
      r1_req = 1'b0; dout_io = 32'h222;
      tick();
      chk("sim_v1", {r1_rvalid, r0_rvalid, r1_rdata}, {2'b10, 32'h222});
      dout_io = 32'hDEAD_BEEF;
      tick();
      // saturation: grants on every other cycle, alternating r0, r1
      r0_req = 1'b1; r1_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         gnt_cnt += int'(r0_gnt) + int'(r1_gnt);
         chk($sformatf("sat_%0d", i), {r1_gnt, r0_gnt}, (i % 2) ? 2'b00 : ((i / 2) % 2 ? 2'b10 : 2'b01));
      end
      r0_req = 1'b0; r1_req = 1'b0;
      chk("sat_total", gnt_cnt, 10);
      tick();
      // reset during ACCESS
      r0_req = 1'b1; r0_adr = IO_CYCLE_CNT;
      tick();
      chk("rst_access", io_en, 1'b1);
      #2 cpu_rst_n = 1'b0;
      #1 chk("rst_async", all_out(), '0);
      r0_req = 1'b0;
      #1 cpu_rst_n = 1'b1;
      tick();
      chk("rst_norv1", all_out(), '0);
      tick();
      chk("rst_norv2", all_out(), '0);
      r1_req = 1'b1; r1_we = 4'h0; r1_adr = IO_INSTR_CNT;
      tick();
      chk("rst_regnt", {r1_gnt, io_en, adr}, {2'b11, IO_INSTR_CNT});
      r1_req = 1'b0; dout_io = 32'h333;
      tick();
      chk("rst_rerv", {r1_rvalid, r1_rdata}, {1'b1, 32'h333});
      tick();
      // request raised during ACCESS waits for the following arbitration
      r0_req = 1'b1; r0_we = 4'h0; r0_adr = IO_CYCLE_CNT;
      tick();
      r0_req = 1'b0;
      r1_req = 1'b1; r1_we = 4'hF; r1_adr = IO_CNT_RST; r1_wdata = 32'h55;
      #1 chk("ign_access", {r0_gnt, r1_gnt, wea, adr, wdata}, {2'b10, 4'h0, IO_CYCLE_CNT, 32'h0});
      dout_io = 32'h77;
      tick();
      chk("ign_resp", {r0_rvalid, r1_gnt, r0_rdata}, {2'b10, 32'h77});
      dout_io = 32'hDEAD_BEEF;
      tick();
      chk("ign_g1", {r1_gnt, wea, adr, wdata}, {1'b1, 4'hF, IO_CNT_RST, 32'h55});
      r1_req = 1'b0;
      tick();
      chk("ign_v1", {r1_rvalid, r1_rdata}, {1'b1, 32'h0});
      tick();
      chk("final_idle", all_out(), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
